// File: rtl/cp0_regfile.sv
// CP0 register file and exception state for the 5-stage MIPS core (WB-stage responder).
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_regfile #(
  parameter logic [31:0] EXC_ENTRY = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cp0_addr,
  input  logic        cp0_wen,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [6:0]  exc_type,
  input  logic [31:0] PC,
  input  logic        is_slot,
  input  logic [5:0]  int_num,
  input  logic [31:0] bad_vaddr,
  input  logic        eret,
  output logic [31:0] EPC,
  output logic        int_happen,
  output logic        cp0_flush,
  output logic [31:0] flush_pc
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;

  logic        exc;
  logic        mtc0;
  logic [4:0]  exc_code_c;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  // An exception in WB drops any mtc0 issued alongside it.
  assign exc  = |exc_type;
  assign mtc0 = cp0_wen & ~exc;

  // ExcCode priority: Int > AdEL > RI > Ov > Sys > Bp > AdES
  always_comb begin
    exc_code_c = CODE_ADES;
    if (exc_type[6])      exc_code_c = CODE_INT;
    else if (exc_type[0]) exc_code_c = CODE_ADEL;
    else if (exc_type[2]) exc_code_c = CODE_RI;
    else if (exc_type[5]) exc_code_c = CODE_OV;
    else if (exc_type[3]) exc_code_c = CODE_SYS;
    else if (exc_type[4]) exc_code_c = CODE_BP;
  end

`ifdef CP0_TIMER_EN
  logic        tick_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  logic        ti_d;

  // A Compare write on the match cycle wins, so TI stays clear.
  always_comb begin
    ti_d = ti_q;
    if (count_q == compare_q) ti_d = 1'b1;
    if (mtc0 && (cp0_addr == ADDR_COMPARE)) ti_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      ti_q      <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (mtc0 && (cp0_addr == ADDR_COUNT)) count_q <= cp0_wdata;
      else if (tick_q)                      count_q <= count_q + 32'd1;
      if (mtc0 && (cp0_addr == ADDR_COMPARE)) compare_q <= cp0_wdata;
      ti_q <= ti_d;
    end
  end

  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  logic ti_q;
  logic ti_d;

  assign ti_q       = 1'b0;
  assign ti_d       = 1'b0;
  assign count_rd   = 32'h0;
  assign compare_rd = 32'h0;
`endif

  // IP[15] samples the next TI so a Compare write drops the interrupt one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      im_q       <= 8'h0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'h0;
      ip_sw_q    <= 2'h0;
      exc_code_q <= 5'h0;
    end else begin
      ip_hw_q <= {int_num[5] | ti_d, int_num[4:0]};
      if (exc) begin
        if (!exl_q) begin
          epc_q <= is_slot ? (PC - 32'd4) : PC;
          bd_q  <= is_slot;
        end
        exl_q      <= 1'b1;
        exc_code_q <= exc_code_c;
        if ((exc_code_c == CODE_ADEL) || (exc_code_c == CODE_ADES)) badvaddr_q <= bad_vaddr;
      end else begin
        if (cp0_wen) begin
          case (cp0_addr)
            ADDR_STATUS: begin
              im_q  <= cp0_wdata[15:8];
              exl_q <= cp0_wdata[1];
              ie_q  <= cp0_wdata[0];
            end
            ADDR_CAUSE: ip_sw_q <= cp0_wdata[9:8];
            ADDR_EPC:   epc_q   <= cp0_wdata;
            default: ;
          endcase
        end
        if (eret) exl_q <= 1'b0;
      end
    end
  end

  assign status_rd = {9'h0, 1'b1, 6'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti_q, 14'h0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_q;
      ADDR_COUNT:    cp0_rdata = count_rd;
      ADDR_COMPARE:  cp0_rdata = compare_rd;
      ADDR_STATUS:   cp0_rdata = status_rd;
      ADDR_CAUSE:    cp0_rdata = cause_rd;
      ADDR_EPC:      cp0_rdata = epc_q;
      default:       cp0_rdata = 32'h0;
    endcase
  end

  assign EPC        = epc_q;
  assign int_happen = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
  assign cp0_flush  = exc | eret;
  assign flush_pc   = (eret && !exc) ? epc_q : EXC_ENTRY;

endmodule
